chip8_mem_arbiter: RTL and testbench

CHIP8_MEM_ARBITER -- requirements
Module: chip8_mem_arbiter

---
 rtl/chip8_mem_pkg.sv | 22 ++
 rtl/chip8_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_chip8_mem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/chip8_mem_pkg.sv
// Shared definitions for the CHIP-8 memory arbiter: default widths, burst limit
// and the arbiter FSM state type.
package chip8_mem_pkg;

    localparam int DEF_ADDR_W  = 12;
    localparam int DEF_DATA_W  = 8;
    localparam int MAX_BURST   = 16;
    localparam int BURST_CNT_W = $clog2(MAX_BURST);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_CPU_ACC   = 2'd1,
        ST_GPU_BURST = 2'd2
    } arb_state_t;

    // Remaining-beats count loaded at burst start; len 0 encodes MAX_BURST and
    // wraps naturally to MAX_BURST-1.
    function automatic logic [BURST_CNT_W-1:0] burst_last(input logic [BURST_CNT_W-1:0] len);
        return len - BURST_CNT_W'(1);
    endfunction

endpackage

// File: rtl/chip8_mem_arbiter.sv
// Single-port memory arbiter between CPU byte accesses and GPU sprite-fetch
// read bursts, round-robin on ties, synchronous 1-cycle-latency memory.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | no access in flight; requests sampled and arbitrated here
// ST_CPU_ACC   | single CPU read/write strobe on the memory port
// ST_GPU_BURST | GPU burst, one read beat per cycle until count hits zero
module chip8_mem_arbiter
    import chip8_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   cpu_req,
    input  logic                   cpu_we,
    input  logic [ADDR_W-1:0]      cpu_addr,
    input  logic [DATA_W-1:0]      cpu_wdata,
    output logic                   cpu_gnt,
    output logic                   cpu_rvalid,
    output logic [DATA_W-1:0]      cpu_rdata,

    input  logic                   gpu_req,
    input  logic [ADDR_W-1:0]      gpu_addr,
    input  logic [BURST_CNT_W-1:0] gpu_len,
    output logic                   gpu_gnt,
    output logic                   gpu_rvalid,
    output logic [DATA_W-1:0]      gpu_rdata,
    output logic                   gpu_done,

    output logic                   mem_en,
    output logic                   mem_we,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    arb_state_t             state_q, state_d;
    logic                   last_gpu_q, last_gpu_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic                   mem_en_q, mem_en_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   cpu_gnt_q, cpu_gnt_d;
    logic                   gpu_gnt_q, gpu_gnt_d;
    logic                   cpu_rvalid_q, cpu_rvalid_d;
    logic                   gpu_rvalid_q, gpu_rvalid_d;
    logic                   gpu_done_q, gpu_done_d;
    logic                   cpu_win;

    always_comb begin
        state_d      = state_q;
        last_gpu_d   = last_gpu_q;
        cnt_d        = cnt_q;
        mem_en_d     = 1'b0;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_gnt_d    = 1'b0;
        gpu_gnt_d    = 1'b0;
        cpu_win      = 1'b0;
        // Read data returns the cycle after the strobe, so valids trail the access.
        cpu_rvalid_d = (state_q == ST_CPU_ACC) && !mem_we_q;
        gpu_rvalid_d = (state_q == ST_GPU_BURST);
        gpu_done_d   = (state_q == ST_GPU_BURST) && (cnt_q == '0);

        case (state_q)
            ST_IDLE: begin
                cpu_win = cpu_req && (!gpu_req || last_gpu_q);
                if (cpu_win) begin
                    state_d     = ST_CPU_ACC;
                    last_gpu_d  = 1'b0;
                    mem_en_d    = 1'b1;
                    mem_we_d    = cpu_we;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    cpu_gnt_d   = 1'b1;
                end else if (gpu_req) begin
                    state_d    = ST_GPU_BURST;
                    last_gpu_d = 1'b1;
                    cnt_d      = burst_last(gpu_len);
                    mem_en_d   = 1'b1;
                    mem_addr_d = gpu_addr;
                    gpu_gnt_d  = 1'b1;
                end
            end
            ST_CPU_ACC: begin
                state_d = ST_IDLE;
            end
            ST_GPU_BURST: begin
                if (cnt_q != '0) begin
                    cnt_d      = cnt_q - BURST_CNT_W'(1);
                    mem_en_d   = 1'b1;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            last_gpu_q   <= 1'b1;
            cnt_q        <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_gnt_q    <= 1'b0;
            gpu_gnt_q    <= 1'b0;
            cpu_rvalid_q <= 1'b0;
            gpu_rvalid_q <= 1'b0;
            gpu_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_gpu_q   <= last_gpu_d;
            cnt_q        <= cnt_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_gnt_q    <= cpu_gnt_d;
            gpu_gnt_q    <= gpu_gnt_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            gpu_rvalid_q <= gpu_rvalid_d;
            gpu_done_q   <= gpu_done_d;
        end
    end

    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign cpu_gnt    = cpu_gnt_q;
    assign gpu_gnt    = gpu_gnt_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign gpu_rvalid = gpu_rvalid_q;
    assign gpu_done   = gpu_done_q;
    assign cpu_rdata  = mem_rdata;
    assign gpu_rdata  = mem_rdata;

endmodule

// File: tb/tb_chip8_mem_arbiter.sv
// Scoreboard bench for chip8_mem_arbiter: a transaction-level arbitration model
// predicts grant/access/read-data events, a negedge monitor pops and compares.
module tb_chip8_mem_arbiter;

    localparam int AW = 12;
    localparam int DW = 8;
    localparam int ID_CG = 0, ID_GG = 1, ID_MEM = 2, ID_CRD = 3, ID_GB = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cpu_req = 1'b0, cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          gpu_req = 1'b0;
    logic [AW-1:0] gpu_addr = '0;
    logic [3:0]    gpu_len = '0;
    logic          gpu_gnt, gpu_rvalid, gpu_done;
    logic [DW-1:0] gpu_rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    chip8_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .gpu_req(gpu_req), .gpu_addr(gpu_addr), .gpu_len(gpu_len),
        .gpu_gnt(gpu_gnt), .gpu_rvalid(gpu_rvalid), .gpu_rdata(gpu_rdata), .gpu_done(gpu_done),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] pmem    [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) pmem[mem_addr] <= mem_wdata;
            else        mem_rdata      <= pmem[mem_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        int            cyc;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          done;
    } ev_t;

    ev_t   q [5][$];
    string nm [5] = '{"cpu_gnt", "gpu_gnt", "mem_access", "cpu_read", "gpu_beat"};
    int    checks = 0;
    int    errors = 0;

    // Reference model state
    int            idle_from = 0;
    bit            last_gpu  = 1'b1;
    logic          s_we;
    logic [AW-1:0] s_caddr, s_gaddr;
    logic [DW-1:0] s_wdata;
    logic [3:0]    s_len;

    function automatic ev_t mk(int c, logic we, logic [AW-1:0] a, logic [DW-1:0] dt, logic dn);
        ev_t e;
        e.cyc = c; e.we = we; e.addr = a; e.data = dt; e.done = dn;
        return e;
    endfunction

    function automatic int imax(int a, int b);
        return (a > b) ? a : b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Serve pending requests in arbitration order, pushing every expected event.
    task automatic predict(input bit has_c, input int cs_in, input bit h_in,
                           input bit has_g, input int gs,
                           output int c_drop, output int g_drop);
        bit pc, pg, hold, cw;
        int cs, tc, tg, t, n;
        logic [AW-1:0] a;
        pc = has_c; pg = has_g; cs = cs_in; hold = h_in;
        c_drop = 0; g_drop = 0;
        while (pc || pg) begin
            tc = pc ? imax(cs, idle_from) : 32'h3fff_ffff;
            tg = pg ? imax(gs, idle_from) : 32'h3fff_ffff;
            cw = pc && (!pg || tc < tg || (tc == tg && last_gpu));
            if (cw) begin
                t = tc;
                q[ID_CG].push_back(mk(t + 1, 1'b0, '0, '0, 1'b0));
                q[ID_MEM].push_back(mk(t + 1, s_we, s_caddr, s_we ? s_wdata : '0, 1'b0));
                if (s_we) ref_mem[s_caddr] = s_wdata;
                else      q[ID_CRD].push_back(mk(t + 2, 1'b0, '0, ref_mem[s_caddr], 1'b0));
                idle_from = t + 2;
                last_gpu  = 1'b0;
                c_drop    = t + 1;
                if (hold) begin
                    hold = 1'b0;
                    cs   = t + 2;
                end else begin
                    pc = 1'b0;
                end
            end else begin
                t = tg;
                n = (s_len == 4'd0) ? 16 : int'(s_len);
                q[ID_GG].push_back(mk(t + 1, 1'b0, '0, '0, 1'b0));
                for (int k = 0; k < n; k++) begin
                    a = s_gaddr + AW'(k);
                    q[ID_MEM].push_back(mk(t + 1 + k, 1'b0, a, '0, 1'b0));
                    q[ID_GB].push_back(mk(t + 2 + k, 1'b0, '0, ref_mem[a], k == n - 1));
                end
                idle_from = t + n + 1;
                last_gpu  = 1'b1;
                g_drop    = t + 1;
                pg        = 1'b0;
            end
        end
    endtask

    // kind: 0 CPU alone, 1 GPU alone, 2 both together, 3 CPU raised d cycles into GPU request
    task automatic run_scn(input int kind, input int d, input bit h);
        int s, cs, cd, gd, endc;
        bit hc, hg;
        s  = cyc;
        hc = (kind != 1);
        hg = (kind != 0);
        cs = (kind == 3) ? s + d : s;
        cpu_we = s_we; cpu_addr = s_caddr; cpu_wdata = s_wdata;
        gpu_addr = s_gaddr; gpu_len = s_len;
        predict(hc, cs, h && (kind == 0), hg, s, cd, gd);
        endc = imax(cd, gd);
        while (cyc < endc) begin
            cpu_req = hc && (cyc >= cs) && (cyc < cd);
            gpu_req = hg && (cyc >= s) && (cyc < gd);
            step();
        end
        cpu_req = 1'b0;
        gpu_req = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if ({mem_en, mem_we, mem_addr, mem_wdata, cpu_gnt, gpu_gnt, cpu_rvalid, gpu_rvalid, gpu_done} !== '0) begin
            errors++;
            $display("FAIL %s: outputs not cleared, got en=%0b we=%0b addr=%h wdata=%h cg=%0b gg=%0b crv=%0b grv=%0b done=%0b, expected all 0",
                     name, mem_en, mem_we, mem_addr, mem_wdata, cpu_gnt, gpu_gnt, cpu_rvalid, gpu_rvalid, gpu_done);
        end
    endtask

    task automatic mon(input int id, input logic fired, input ev_t got);
        ev_t e;
        while (q[id].size() > 0 && q[id][0].cyc < cyc) begin
            e = q[id].pop_front();
            checks++; errors++;
            $display("FAIL %s missing: expected event at cycle %0d not seen (now %0d)", nm[id], e.cyc, cyc);
        end
        if (fired) begin
            checks++;
            if (q[id].size() == 0) begin
                errors++;
                $display("FAIL %s unexpected at cycle %0d: got addr=%h data=%h, expected no event",
                         nm[id], cyc, got.addr, got.data);
            end else begin
                e = q[id].pop_front();
                if (e !== got) begin
                    errors++;
                    $display("FAIL %s: got t=%0d we=%0b addr=%h data=%h done=%0b, expected t=%0d we=%0b addr=%h data=%h done=%0b",
                             nm[id], got.cyc, got.we, got.addr, got.data, got.done,
                             e.cyc, e.we, e.addr, e.data, e.done);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_gnt || gpu_gnt) begin
                checks++;
                if (cpu_gnt && gpu_gnt) begin
                    errors++;
                    $display("FAIL dual_grant at cycle %0d: got cpu_gnt=1 gpu_gnt=1, expected at most one", cyc);
                end
            end
            if (gpu_done) begin
                checks++;
                if (!gpu_rvalid) begin
                    errors++;
                    $display("FAIL done_alone at cycle %0d: got gpu_done=1 gpu_rvalid=0, expected rvalid with done", cyc);
                end
            end
            mon(ID_CG,  cpu_gnt,    mk(cyc, 1'b0, '0, '0, 1'b0));
            mon(ID_GG,  gpu_gnt,    mk(cyc, 1'b0, '0, '0, 1'b0));
            mon(ID_MEM, mem_en,     mk(cyc, mem_we, mem_addr, mem_we ? mem_wdata : '0, 1'b0));
            mon(ID_CRD, cpu_rvalid, mk(cyc, 1'b0, '0, cpu_rdata, 1'b0));
            mon(ID_GB,  gpu_rvalid, mk(cyc, 1'b0, '0, gpu_rdata, gpu_done));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cd, gd, kind;
        for (int i = 0; i < (1 << AW); i++) begin
            pmem[i]    = DW'($urandom);
            ref_mem[i] = pmem[i];
        end
        pmem[12'h200] = 8'hA2; ref_mem[12'h200] = 8'hA2;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset_initial");
        rst_n = 1'b1;
        idle_from = cyc; last_gpu = 1'b1;
        step();

        // Tie after reset: CPU first, GPU next; second tie again CPU (GPU was last)
        s_we = 1'b0; s_caddr = 12'h123; s_wdata = '0; s_gaddr = 12'h050; s_len = 4'd5;
        run_scn(2, 0, 1'b0);
        s_caddr = 12'h124;
        run_scn(2, 0, 1'b0);

        // CPU read 0x200, write 0x300 then read back
        repeat (2) step();
        s_we = 1'b0; s_caddr = 12'h200;
        run_scn(0, 0, 1'b0);
        s_we = 1'b1; s_caddr = 12'h300; s_wdata = 8'h5A;
        run_scn(0, 0, 1'b0);
        s_we = 1'b0;
        run_scn(0, 0, 1'b0);

        // Wrapping bursts: 0xFFE len 3 and len 0 (16 beats)
        s_gaddr = 12'hFFE; s_len = 4'd3;
        run_scn(1, 0, 1'b0);
        s_len = 4'd0;
        run_scn(1, 0, 1'b0);

        // CPU write arriving mid 5-beat burst
        step();
        s_we = 1'b1; s_caddr = 12'h301; s_wdata = 8'hC3; s_gaddr = 12'h400; s_len = 4'd5;
        run_scn(3, 2, 1'b0);

        // Reset during third beat of an 8-beat burst
        step();
        s_gaddr = 12'h123; s_len = 4'd8;
        gpu_addr = s_gaddr; gpu_len = s_len;
        predict(1'b0, 0, 1'b0, 1'b1, cyc, cd, gd);
        while (cyc < gd + 2) begin
            gpu_req = (cyc < gd);
            step();
        end
        gpu_req = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_mid_burst");
        for (int id = 0; id < 5; id++)
            while (q[id].size() > 0 && q[id][$].cyc >= cyc) void'(q[id].pop_back());
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_from = cyc; last_gpu = 1'b1;
        step();
        s_we = 1'b0; s_caddr = 12'h300;
        run_scn(0, 0, 1'b0);

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            kind    = $urandom_range(0, 3);
            s_we    = $urandom_range(0, 1);
            s_caddr = $urandom_range(0, 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
            s_wdata = DW'($urandom);
            s_gaddr = $urandom_range(0, 3) == 0 ? AW'(12'hFF0 + $urandom_range(0, 15)) : AW'($urandom_range(0, 31));
            s_len   = 4'($urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) step();
            run_scn(kind, $urandom_range(1, 16), $urandom_range(0, 3) == 0);
        end

        while (cyc < idle_from + 4) step();
        for (int id = 0; id < 5; id++) begin
            checks++;
            if (q[id].size() != 0) begin
                errors++;
                $display("FAIL %s leftover: got %0d unserved events, expected 0", nm[id], q[id].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
